// File: rtl/apb_mul_pkg.sv
// Shared types and constants for the APB multi-slave sandbox.
package apb_mul_pkg;

   localparam int unsigned DEF_ADDR_W = 4;
   localparam int unsigned DEF_DATA_W = 8;

   localparam logic [1:0] SLV1 = 2'b01;
   localparam logic [1:0] SLV2 = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } state_e;

endpackage

// File: rtl/apb_ram_slave.sv
// Zero-wait-state APB RAM slave; flags X/Z address or write data as a slave error.
module apb_ram_slave #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 8
) (
   input  logic              pclk,
   input  logic              presetn,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [DATA_W-1:0] pwdata,
   output logic [DATA_W-1:0] prdata,
   output logic              pready,
   output logic              pslverr
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic              w_access;
   logic              w_bad;

   assign w_access = psel & penable;
   // Only meaningful in a 4-state simulator; hardware never sees X.
   assign w_bad    = $isunknown(paddr) | $isunknown(pwdata);
   assign pready   = w_access;
   assign pslverr  = w_access & w_bad;
   assign prdata   = (w_access & ~pwrite & ~w_bad) ? r_mem[paddr] : '0;

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_access & pwrite & ~w_bad) begin
         r_mem[paddr] <= pwdata;
      end
   end

endmodule

// File: rtl/apb_mul_slave.sv
// Request-driven APB master FSM with two RAM slaves, select decode and result mux.
module apb_mul_slave
   import apb_mul_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic              pclk,
   input  logic              presetn,
   input  logic [1:0]        slv_addr_in,
   input  logic [ADDR_W-1:0] addrin,
   input  logic [DATA_W-1:0] datain,
   input  logic              wr,
   input  logic              newd,
   output logic              slverr_o,
   output logic [DATA_W-1:0] dataout
);

   state_e            r_state;
   state_e            w_state_nxt;
   logic [1:0]        r_sel;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_wr;

   logic              w_capture;
   logic              w_done;
   logic              w_busy;
   logic              w_psel1;
   logic              w_psel2;
   logic              w_penable;
   logic              w_pready;
   logic              w_err;
   logic [DATA_W-1:0] w_prdata;
   logic [DATA_W-1:0] w_prdata1;
   logic [DATA_W-1:0] w_prdata2;
   logic              w_pready1;
   logic              w_pready2;
   logic              w_pslverr1;
   logic              w_pslverr2;

   assign w_busy    = (r_state != IDLE);
   assign w_psel1   = w_busy & (r_sel == SLV1);
   assign w_psel2   = w_busy & (r_sel == SLV2);
   assign w_penable = (r_state == ACCESS);

   // Invalid selects complete on their own with an error and no bus activity.
   always_comb begin
      w_pready = 1'b1;
      w_err    = 1'b1;
      w_prdata = '0;
      unique case (r_sel)
         SLV1: begin
            w_pready = w_pready1;
            w_err    = w_pslverr1;
            w_prdata = w_prdata1;
         end
         SLV2: begin
            w_pready = w_pready2;
            w_err    = w_pslverr2;
            w_prdata = w_prdata2;
         end
         default: ;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_done      = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (newd) begin
               w_capture   = 1'b1;
               w_state_nxt = SETUP;
            end
         end
         SETUP: w_state_nxt = ACCESS;
         ACCESS: begin
            if (w_pready) begin
               w_done = 1'b1;
               if (newd) begin
                  w_capture   = 1'b1;
                  w_state_nxt = SETUP;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_sel   <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wr    <= 1'b0;
      end else if (w_capture) begin
         r_sel   <= slv_addr_in;
         r_addr  <= addrin;
         r_wdata <= datain;
         r_wr    <= wr;
      end
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         slverr_o <= 1'b0;
         dataout  <= '0;
      end else if (w_done) begin
         slverr_o <= w_err;
         if (!r_wr) begin
            dataout <= w_err ? '0 : w_prdata;
         end
      end
   end

   apb_ram_slave #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_slave1 (
      .pclk    (pclk),
      .presetn (presetn),
      .psel    (w_psel1),
      .penable (w_penable),
      .pwrite  (r_wr),
      .paddr   (r_addr),
      .pwdata  (r_wdata),
      .prdata  (w_prdata1),
      .pready  (w_pready1),
      .pslverr (w_pslverr1)
   );

   apb_ram_slave #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_slave2 (
      .pclk    (pclk),
      .presetn (presetn),
      .psel    (w_psel2),
      .penable (w_penable),
      .pwrite  (r_wr),
      .paddr   (r_addr),
      .pwdata  (r_wdata),
      .prdata  (w_prdata2),
      .pready  (w_pready2),
      .pslverr (w_pslverr2)
   );

endmodule

// File: tb/tb_apb_mul_slave.sv
// Bench for apb_mul_slave: directed sweeps plus random bursts against a memory-array model.
module tb_apb_mul_slave;

   typedef struct {
      logic [1:0] sel;
      logic [3:0] addr;
      logic [7:0] data;
      logic       wr;
   } req_t;

   logic       pclk;
   logic       presetn;
   logic [1:0] slv_addr_in;
   logic [3:0] addrin;
   logic [7:0] datain;
   logic       wr;
   logic       newd;
   logic       slverr_o;
   logic [7:0] dataout;

   int n_checks;
   int n_errors;

   logic [7:0] mem1 [16];
   logic [7:0] mem2 [16];
   logic       exp_err;
   logic [7:0] exp_dout;
   req_t       req_q [$];

   apb_mul_slave dut (
      .pclk        (pclk),
      .presetn     (presetn),
      .slv_addr_in (slv_addr_in),
      .addrin      (addrin),
      .datain      (datain),
      .wr          (wr),
      .newd        (newd),
      .slverr_o    (slverr_o),
      .dataout     (dataout)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         mem1[i] = 8'h00;
         mem2[i] = 8'h00;
      end
      exp_err  = 1'b0;
      exp_dout = 8'h00;
   endtask

   // A transfer is good only for a known select with fully known address and data.
   task automatic model_apply(input req_t r);
      logic bad;
      bad = !(r.sel == 2'b01 || r.sel == 2'b10) || $isunknown(r.addr) || $isunknown(r.data);
      exp_err = bad;
      if (r.wr) begin
         if (!bad) begin
            if (r.sel == 2'b01) mem1[r.addr] = r.data;
            else                mem2[r.addr] = r.data;
         end
      end else begin
         if (bad)                 exp_dout = 8'h00;
         else if (r.sel == 2'b01) exp_dout = mem1[r.addr];
         else                     exp_dout = mem2[r.addr];
      end
   endtask

   task automatic drive(input req_t r);
      slv_addr_in = r.sel;
      addrin      = r.addr;
      datain      = r.data;
      wr          = r.wr;
   endtask

   task automatic push(input logic [1:0] s, input logic [3:0] a, input logic [7:0] d,
                       input logic w);
      req_t r;
      r.sel  = s;
      r.addr = a;
      r.data = d;
      r.wr   = w;
      req_q.push_back(r);
   endtask

   // Back-to-back burst: next request is presented right after each capture edge,
   // so in-flight transfers must ignore later input changes.
   task automatic run_burst(input string tag);
      int n;
      n = req_q.size();
      if (n == 0) return;
      drive(req_q[0]);
      newd = 1'b1;
      @(posedge pclk); #1;
      for (int i = 0; i < n; i++) begin
         if (i + 1 < n) begin
            drive(req_q[i+1]);
         end else begin
            newd        = 1'b0;
            slv_addr_in = 2'($urandom_range(0, 3));
            addrin      = 4'($urandom);
            datain      = 8'($urandom);
            wr          = 1'($urandom);
         end
         @(posedge pclk); #1;
         @(posedge pclk); #1;
         model_apply(req_q[i]);
         check_eq($sformatf("%s_err[%0d]", tag, i), {31'd0, slverr_o}, {31'd0, exp_err});
         check_eq($sformatf("%s_dout[%0d]", tag, i), {24'd0, dataout}, {24'd0, exp_dout});
      end
      req_q.delete();
   endtask

   initial begin
      logic [3:0] probe;
      logic [3:0] xaddr;
      logic [7:0] xdata;
      n_checks    = 0;
      n_errors    = 0;
      presetn     = 1'b0;
      newd        = 1'b0;
      slv_addr_in = 2'b00;
      addrin      = 4'h0;
      datain      = 8'h00;
      wr          = 1'b0;
      model_reset();
      repeat (2) @(posedge pclk);
      #1;
      check_eq("rst_err", {31'd0, slverr_o}, 32'd0);
      check_eq("rst_dout", {24'd0, dataout}, 32'd0);
      presetn = 1'b1;
      @(posedge pclk); #1;

      for (int i = 1; i <= 9; i++) begin
         push(2'b01, 4'(i), 8'(5 * i), 1'b1);
         push(2'b10, 4'(i), 8'(10 * i), 1'b1);
      end
      run_burst("wsweep");

      push(2'b01, 4'd3, 8'h00, 1'b0);
      push(2'b10, 4'd9, 8'h00, 1'b0);
      run_burst("rdback");
      check_eq("rd_s2_a9", {24'd0, dataout}, 32'h5A);
      push(2'b01, 4'd3, 8'h00, 1'b0);
      run_burst("rd_s1_a3");
      check_eq("rd_s1_a3_lit", {24'd0, dataout}, 32'h0F);
      push(2'b01, 4'd9, 8'h00, 1'b0);
      run_burst("iso");
      check_eq("iso_lit", {24'd0, dataout}, 32'h2D);

      push(2'b00, 4'd2, 8'hAA, 1'b1);
      run_burst("inv_wr");
      check_eq("inv_wr_err_lit", {31'd0, slverr_o}, 32'd1);
      push(2'b01, 4'd2, 8'h00, 1'b0);
      run_burst("after_inv");
      check_eq("after_inv_lit", {24'd0, dataout}, 32'd10);
      push(2'b11, 4'd2, 8'h00, 1'b0);
      push(2'b10, 4'd4, 8'h00, 1'b0);
      run_burst("inv_rd");

      for (int i = 0; i < 60; i++) begin
         push(2'($urandom_range(0, 3)), 4'($urandom), 8'($urandom), 1'($urandom));
      end
      run_burst("rand");

      // X-based errors only exist in a 4-state simulator.
      probe = 4'bxxxx;
      if ($isunknown(probe)) begin
         xaddr = 4'bxx00;
         push(2'b01, xaddr, 8'h33, 1'b1);
         xdata = 8'b1010_x0x1;
         push(2'b10, 4'd6, xdata, 1'b1);
         for (int a = 0; a < 16; a += 4) push(2'b01, 4'(a), 8'h00, 1'b0);
         push(2'b10, 4'd6, 8'h00, 1'b0);
         run_burst("xstim");
      end

      push(2'b01, 4'd5, 8'h00, 1'b1);
      run_burst("pre_rst");
      drive('{sel: 2'b01, addr: 4'd3, data: 8'h00, wr: 1'b0});
      newd = 1'b1;
      @(posedge pclk); #1;
      drive('{sel: 2'b01, addr: 4'd5, data: 8'h77, wr: 1'b1});
      @(posedge pclk); #1;
      @(posedge pclk); #1;
      model_apply('{sel: 2'b01, addr: 4'd3, data: 8'h00, wr: 1'b0});
      check_eq("pre_abort_dout", {24'd0, dataout}, {24'd0, exp_dout});
      newd = 1'b0;
      @(posedge pclk); #1;
      presetn = 1'b0;
      #1;
      model_reset();
      check_eq("abort_err", {31'd0, slverr_o}, {31'd0, exp_err});
      check_eq("abort_dout", {24'd0, dataout}, {24'd0, exp_dout});
      @(posedge pclk); #1;
      presetn = 1'b1;
      @(posedge pclk); #1;
      push(2'b01, 4'd5, 8'h00, 1'b0);
      push(2'b10, 4'd9, 8'h00, 1'b0);
      push(2'b01, 4'd3, 8'h00, 1'b0);
      run_burst("post_rst");
      check_eq("post_rst_lit", {24'd0, dataout}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
